// File: rtl/cpu0_pkg.sv
// Shared cpu0 definitions: access size codes, memory map constants,
// arbiter state encoding and an address range helper.
package cpu0_pkg;

    localparam logic [1:0] INT32 = 2'd3;
    localparam logic [1:0] INT24 = 2'd2;
    localparam logic [1:0] INT16 = 2'd1;
    localparam logic [1:0] BYTE  = 2'd0;

    localparam logic [31:0] MEMSIZE  = 32'h0000_7000;
    localparam logic [31:0] IOADDR   = 32'hFF00_0000;
    localparam logic [7:0]  MEMEMPTY = 8'hFF;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    // A 32-bit access starting above memsize-4 would run off the end.
    function automatic logic addr_oor(
        input logic [31:0] addr,
        input logic [31:0] memsize
    );
        return addr > (memsize - 32'd4);
    endfunction

endpackage

// File: rtl/cpu0_mem_arbiter_if.sv
// Bus bundle of the two-master cpu0 memory arbiter.
// Ports: m0_*/m1_* req/ack masters, mem_* memory port, grant/busy status.
interface cpu0_mem_arbiter_if;

    logic        m0_req;
    logic        m0_rw;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic        m1_rw;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic        mem_en;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_abus;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        grant;
    logic        busy;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_rw, m0_size, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_rw, m1_size, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output mem_en, mem_rw, mem_size, mem_abus, mem_wdata,
        input  mem_rdata,
        output grant, busy
    );

    // Environment side: masters plus memory.
    modport master (
        output m0_req, m0_rw, m0_size, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_rw, m1_size, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  mem_en, mem_rw, mem_size, mem_abus, mem_wdata,
        output mem_rdata,
        input  grant, busy
    );

endinterface

// File: rtl/cpu0_arb_rr2.sv
// Two-way round-robin picker.
// Ports: req[1:0] requests, last = previous winner; valid, winner id.
module cpu0_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        unique case (1'b1)
            (req == 2'b11): winner = ~last;
            (req == 2'b10): winner = 1'b1;
            default:        winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// Shares the cpu0 memory port between two req/ack masters, round-robin.
// Ports: clock, reset (sync, active-high), bus (slave modport).
module cpu0_mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter logic [31:0] MEMSIZE       = cpu0_pkg::MEMSIZE
) (
    input  logic               clock,
    input  logic               reset,
    cpu0_mem_arbiter_if.slave  bus
);

    import cpu0_pkg::*;

    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

    arb_state_e state_q, state_d;

    logic              last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic [31:0]       mem_abus_q, mem_abus_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0][31:0]  rdata_q, rdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;

    logic              pick_valid;
    logic              pick_id;
    logic              sel_rw;
    logic [1:0]        sel_size;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;

    cpu0_arb_rr2 u_rr (
        .req    ({bus.m1_req, bus.m0_req}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_comb begin
        sel_rw    = bus.m0_rw;
        sel_size  = bus.m0_size;
        sel_addr  = bus.m0_addr;
        sel_wdata = bus.m0_wdata;
        if (pick_id) begin
            sel_rw    = bus.m1_rw;
            sel_size  = bus.m1_size;
            sel_addr  = bus.m1_addr;
            sel_wdata = bus.m1_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_size_d  = mem_size_q;
        mem_abus_d  = mem_abus_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_id;
                    last_d      = pick_id;
                    mem_rw_d    = sel_rw;
                    mem_size_d  = sel_size;
                    mem_abus_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    if (addr_oor(sel_addr, MEMSIZE)) begin
                        // Bad address: answer straight away, memory untouched.
                        ack_d[pick_id]   = 1'b1;
                        err_d[pick_id]   = 1'b1;
                        rdata_d[pick_id] = '0;
                        state_d          = ARB_RESP;
                    end else begin
                        cnt_d    = CNT_LOAD;
                        mem_en_d = 1'b1;
                        state_d  = ARB_ACCESS;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    mem_en_d       = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    if (mem_rw_q) begin
                        rdata_d[grant_q] = bus.mem_rdata;
                    end
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d  = ARB_IDLE;
                mem_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_abus_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_size_q  <= mem_size_d;
            mem_abus_q  <= mem_abus_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_abus  = mem_abus_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Bench for cpu0_mem_arbiter: one instance with 1 access cycle, one with 4.
// Expected memory accesses and responses are queued; a monitor checks them.
module tb_cpu0_mem_arbiter;

    import cpu0_pkg::*;

    logic clock = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clock = ~clock;

    cpu0_mem_arbiter_if bus_a ();
    cpu0_mem_arbiter_if bus_b ();

    cpu0_mem_arbiter #(.ACCESS_CYCLES(1), .MEMSIZE(MEMSIZE)) dut_a (
        .clock (clock),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    cpu0_mem_arbiter #(.ACCESS_CYCLES(4), .MEMSIZE(MEMSIZE)) dut_b (
        .clock (clock),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {16'hA5A5, a[15:0]};
    endfunction

    assign bus_a.mem_rdata = mem_model(bus_a.mem_abus);
    assign bus_b.mem_rdata = mem_model(bus_b.mem_abus);

    logic [1:0]  ack [2];
    logic [1:0]  err [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic        men [2];
    logic        mrw [2];
    logic [1:0]  msz [2];
    logic [31:0] mab [2];
    logic [31:0] mwd [2];
    logic        gnt [2];
    logic        bsy [2];

    assign ack[0] = {bus_a.m1_ack, bus_a.m0_ack};
    assign ack[1] = {bus_b.m1_ack, bus_b.m0_ack};
    assign err[0] = {bus_a.m1_err, bus_a.m0_err};
    assign err[1] = {bus_b.m1_err, bus_b.m0_err};
    assign rd0[0] = bus_a.m0_rdata;
    assign rd0[1] = bus_b.m0_rdata;
    assign rd1[0] = bus_a.m1_rdata;
    assign rd1[1] = bus_b.m1_rdata;
    assign men[0] = bus_a.mem_en;
    assign men[1] = bus_b.mem_en;
    assign mrw[0] = bus_a.mem_rw;
    assign mrw[1] = bus_b.mem_rw;
    assign msz[0] = bus_a.mem_size;
    assign msz[1] = bus_b.mem_size;
    assign mab[0] = bus_a.mem_abus;
    assign mab[1] = bus_b.mem_abus;
    assign mwd[0] = bus_a.mem_wdata;
    assign mwd[1] = bus_b.mem_wdata;
    assign gnt[0] = bus_a.grant;
    assign gnt[1] = bus_b.grant;
    assign bsy[0] = bus_a.busy;
    assign bsy[1] = bus_b.busy;

    typedef struct {
        int          d;
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          d;
        logic        rw;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        g;
    } mem_t;

    resp_t rq[$];
    mem_t  mq[$];
    mem_t  cur [2];
    logic  men_prev [2] = '{1'b0, 1'b0};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input int d, input logic rw, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic g);
        mem_t e;
        e.d = d; e.rw = rw; e.sz = sz; e.a = a; e.wd = wd; e.g = g;
        mq.push_back(e);
    endtask

    task automatic exp_resp(input int d, input logic id,
                            input logic [31:0] rdata, input logic e_err);
        resp_t e;
        e.d = d; e.id = id; e.rdata = rdata; e.err = e_err;
        rq.push_back(e);
    endtask

    // Monitor: memory accesses and master responses against the queues.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (men[d] && !men_prev[d]) begin
                if (mq.size() == 0 || mq[0].d != d) begin
                    chk("mem_unexpected", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    cur[d] = mq.pop_front();
                end
            end
            if (men[d]) begin
                chk("mem_rw", mrw[d], cur[d].rw);
                chk("mem_size", msz[d], cur[d].sz);
                chk("mem_abus", mab[d], cur[d].a);
                chk("mem_wdata", mwd[d], cur[d].wd);
                chk("mem_grant", gnt[d], cur[d].g);
            end
            if (ack[d] != 2'b00) begin
                if (rq.size() == 0 || rq[0].d != d) begin
                    chk("ack_unexpected", ack[d], 2'b00);
                end else begin
                    resp_t e;
                    e = rq.pop_front();
                    chk("ack_id", ack[d], e.id ? 2'b10 : 2'b01);
                    chk("rdata", e.id ? rd1[d] : rd0[d], e.rdata);
                    chk("err", err[d],
                        e.err ? (e.id ? 2'b10 : 2'b01) : 2'b00);
                    chk("ack_after_mem", men_prev[d], !e.err);
                end
            end else begin
                chk("err_no_ack", err[d], 2'b00);
            end
            men_prev[d] = men[d];
        end
    end

    task automatic set_m(input int d, input int m, input logic req,
                         input logic rw, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0 && m == 0) begin
            bus_a.m0_req = req; bus_a.m0_rw = rw; bus_a.m0_size = sz;
            bus_a.m0_addr = a; bus_a.m0_wdata = wd;
        end else if (d == 0) begin
            bus_a.m1_req = req; bus_a.m1_rw = rw; bus_a.m1_size = sz;
            bus_a.m1_addr = a; bus_a.m1_wdata = wd;
        end else if (m == 0) begin
            bus_b.m0_req = req; bus_b.m0_rw = rw; bus_b.m0_size = sz;
            bus_b.m0_addr = a; bus_b.m0_wdata = wd;
        end else begin
            bus_b.m1_req = req; bus_b.m1_rw = rw; bus_b.m1_size = sz;
            bus_b.m1_addr = a; bus_b.m1_wdata = wd;
        end
    endtask

    task automatic drop(input int d, input int m);
        if (d == 0 && m == 0) bus_a.m0_req = 1'b0;
        else if (d == 0)      bus_a.m1_req = 1'b0;
        else if (m == 0)      bus_b.m0_req = 1'b0;
        else                  bus_b.m1_req = 1'b0;
    endtask

    int n;
    int lastc;

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        set_m(0, 1, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
        set_m(1, 0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
        set_m(1, 1, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
        set_m(0, 0, 1'b1, 1'b1, INT32, 32'h10, 32'h0);

        // Reset held 3 cycles with m0 requesting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_mem_en", men[0], 1'b0);
            chk("rst_ack", ack[0], 2'b00);
            chk("rst_busy", bsy[0], 1'b0);
            chk("rst_grant", gnt[0], 1'b0);
        end
        chk("rst_abus", mab[0], 32'h0);
        chk("rst_wdata", mwd[0], 32'h0);
        chk("rst_rw_size", {mrw[0], msz[0]}, 3'b000);
        chk("rst_rdata0", rd0[0], 32'h0);
        chk("rst_rdata1", rd1[0], 32'h0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Single read right out of reset: this is cycle 0.
        exp_mem(0, 1'b1, INT32, 32'h10, 32'h0, 1'b0);
        exp_resp(0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clock);
        chk("rd_en_c1", men[0], 1'b1);
        chk("rd_noack_c1", ack[0], 2'b00);
        chk("rd_busy_c1", bsy[0], 1'b1);
        @(negedge clock);
        chk("rd_ack_c2", ack[0], 2'b01);
        chk("rd_en_c2", men[0], 1'b0);
        drop(0, 0);
        @(negedge clock);
        chk("rd_idle", bsy[0], 1'b0);

        // Out of range read by m1.
        set_m(0, 1, 1'b1, 1'b1, INT32, 32'h6FFD, 32'h0);
        exp_resp(0, 1'b1, 32'h0, 1'b1);
        @(negedge clock);
        chk("oor_ack_c1", ack[0], 2'b10);
        chk("oor_no_en", men[0], 1'b0);
        chk("oor_grant", gnt[0], 1'b1);
        drop(0, 1);
        @(negedge clock);

        // Highest legal address.
        set_m(0, 1, 1'b1, 1'b1, INT32, 32'h6FFC, 32'h0);
        exp_mem(0, 1'b1, INT32, 32'h6FFC, 32'h0, 1'b1);
        exp_resp(0, 1'b1, 32'hA5A5_6FFC, 1'b0);
        @(negedge clock);
        chk("edge_en", men[0], 1'b1);
        @(negedge clock);
        chk("edge_ack", ack[0], 2'b10);
        drop(0, 1);
        @(negedge clock);

        // Contention: both hold req, expect 0,1,0,1.
        set_m(0, 0, 1'b1, 1'b1, INT32, 32'h0, 32'h0);
        set_m(0, 1, 1'b1, 1'b0, BYTE, 32'h20, 32'h1234_5678);
        for (int k = 0; k < 2; k++) begin
            exp_mem(0, 1'b1, INT32, 32'h0, 32'h0, 1'b0);
            exp_resp(0, 1'b0, 32'hA5A5_0000, 1'b0);
            exp_mem(0, 1'b0, BYTE, 32'h20, 32'h1234_5678, 1'b1);
            exp_resp(0, 1'b1, 32'hA5A5_6FFC, 1'b0);
        end
        n = 0;
        lastc = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clock);
            if (ack[0] != 2'b00) begin
                n++;
                if (n > 1) chk("cont_gap", 32'(c - lastc), 32'd3);
                lastc = c;
                if (n == 4) begin
                    drop(0, 0);
                    drop(0, 1);
                end
            end
        end
        chk("cont_acks", 32'(n), 32'd4);
        drop(0, 0);
        drop(0, 1);

        // Wait states on the 4-cycle instance.
        @(negedge clock);
        set_m(1, 0, 1'b1, 1'b1, INT32, 32'h40, 32'h0);
        set_m(1, 1, 1'b1, 1'b0, INT16, 32'h44, 32'h0000_BEEF);
        exp_mem(1, 1'b1, INT32, 32'h40, 32'h0, 1'b0);
        exp_resp(1, 1'b0, 32'hA5A5_0040, 1'b0);
        exp_mem(1, 1'b0, INT16, 32'h44, 32'h0000_BEEF, 1'b1);
        exp_resp(1, 1'b1, 32'h0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clock);
            if (c <= 4) begin
                chk("ws_en", men[1], 1'b1);
                chk("ws_grant0", gnt[1], 1'b0);
            end else if (c == 5) begin
                chk("ws_ack0", ack[1], 2'b01);
                chk("ws_en_off", men[1], 1'b0);
                drop(1, 0);
            end else if (c == 6) begin
                chk("ws_gap", men[1], 1'b0);
            end else if (c == 7) begin
                chk("ws_en1", men[1], 1'b1);
                chk("ws_grant1", gnt[1], 1'b1);
            end else if (c == 8) begin
                drop(1, 1);
            end else if (c == 11) begin
                chk("ws_ack1", ack[1], 2'b10);
            end
        end

        // Abort: reset during the second access cycle.
        @(negedge clock);
        set_m(1, 0, 1'b1, 1'b1, INT32, 32'h80, 32'h0);
        exp_mem(1, 1'b1, INT32, 32'h80, 32'h0, 1'b0);
        @(negedge clock);
        chk("ab_en_c1", men[1], 1'b1);
        @(negedge clock);
        reset_b = 1'b1;
        drop(1, 0);
        @(negedge clock);
        chk("ab_en_off", men[1], 1'b0);
        chk("ab_busy", bsy[1], 1'b0);
        chk("ab_ack", ack[1], 2'b00);
        chk("ab_grant", gnt[1], 1'b0);
        reset_b = 1'b0;
        set_m(1, 0, 1'b1, 1'b1, INT32, 32'h84, 32'h0);
        set_m(1, 1, 1'b1, 1'b1, INT32, 32'h88, 32'h0);
        exp_mem(1, 1'b1, INT32, 32'h84, 32'h0, 1'b0);
        exp_resp(1, 1'b0, 32'hA5A5_0084, 1'b0);
        exp_mem(1, 1'b1, INT32, 32'h88, 32'h0, 1'b1);
        exp_resp(1, 1'b1, 32'hA5A5_0088, 1'b0);
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clock);
            if (c == 0) begin
                chk("ab_last_m0", gnt[1], 1'b0);
                chk("ab_restart_en", men[1], 1'b1);
            end
            if (ack[1][0]) begin
                drop(1, 0);
                n++;
            end
            if (ack[1][1]) begin
                drop(1, 1);
                n++;
            end
        end
        chk("ab_acks", 32'(n), 32'd2);
        drop(1, 0);
        drop(1, 1);

        repeat (3) @(negedge clock);
        chk("resp_q_empty", 32'(rq.size()), 32'd0);
        chk("mem_q_empty", 32'(mq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu0_mem_arbiter.md
# cpu0_mem_arbiter

Two-master arbiter that shares the single cpu0 memory port (en/rw/size/abus/dbus) between master 0 (cpu0 core) and master 1 (DMA or debug loader). Each master runs a req/ack handshake. The arbiter grants one master at a time by round-robin, sequences a fixed-length memory access, and returns the read data and an error flag. It sits between the masters and memory0 and replaces the direct cpu0-to-memory0 wiring.

## Interface
- `ACCESS_CYCLES`, default 1: cycles `mem_en` is held per access; legal range ≥1.
- `MEMSIZE`, default 'h7000: memory size in bytes.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_req`, `m1_req`  in  1  request; held high until ack.
- `m0_rw`, `m1_rw`  in  1  1 = read, 0 = write.
- `m0_size`, `m1_size`  in  2  size code: INT32=3, INT24=2, INT16=1, BYTE=0.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data; valid while ack is high, otherwise holds its last value.
- `m0_err`, `m1_err`  out  1  valid with ack; 1 = out-of-range address.
- `mem_en`  out  1  memory enable.
- `mem_rw`  out  1  memory direction.
- `mem_size`  out  2  memory access size.
- `mem_abus`  out  32  memory address.
- `mem_wdata`  out  32  write data to memory (dbus_in).
- `mem_rdata`  in  32  read data from memory (dbus_out); combinational.
- `grant`  out  1  id of the master currently being served.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- All outputs are registered.
- Reset values: state IDLE; all ack, err and `mem_en` are 0; `mem_rw` 0; `mem_size` 0; `mem_abus`, `mem_wdata` and both rdata outputs 0; `grant` 0; `busy` 0; round-robin pointer `last`=1, so master 0 wins first.
- States: IDLE, ACCESS, RESP.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If one request is high, grant that master.
  - If both are high, grant the master that is not `last`.
  - On a grant: latch rw, size, addr and wdata of the winner; set `grant` and `last` to the winner.
  - If addr > MEMSIZE-4 (unsigned): no memory access; set err; go to RESP.
  - Otherwise: load the counter with ACCESS_CYCLES-1; drive `mem_en`=1 and the `mem_*` fields; go to ACCESS.
- **ACCESS:**
  - `mem_en` and all `mem_*` fields are held stable.
  - While the counter is non-zero, decrement it.
  - When the counter is 0: if read, capture `mem_rdata` into the granted master's rdata; deassert `mem_en`; go to RESP.
- **RESP:**
  - The granted master's ack is 1 for exactly this cycle.
  - A write returns rdata unchanged. An error returns rdata=0 and err=1.
  - Go to IDLE.
- Read data is passed through as memory0 returns it (zero-extended for BYTE/INT16/INT24). Sign extension is the master's job.
- The non-granted master's ack and err stay 0.
- A master that drops req before its ack still gets its transaction completed and acked.
- A req that is still high in the IDLE cycle after the ack counts as a new request.
- A reset at any point aborts the transaction: no ack is issued, and `mem_en` is 0 from the next cycle.

## Timing
- Request sampled in IDLE at cycle 0.
- `mem_en`=1 during cycles 1..ACCESS_CYCLES.
- Ack high in cycle ACCESS_CYCLES+1.
- Next grant at the earliest in cycle ACCESS_CYCLES+2, so peak throughput is one access per ACCESS_CYCLES+2 cycles.
- Error path: ack in cycle 1, no `mem_en` pulse.
- With both masters requesting continuously, grants strictly alternate 0,1,0,1.
- The counter is $clog2(ACCESS_CYCLES+1) bits wide and never wraps: it is loaded only in IDLE.

## Structure
- Shared package `cpu0_pkg` holds:
  - size codes INT32/INT24/INT16/BYTE;
  - MEMSIZE, IOADDR and MEMEMPTY;
  - the arbiter state enumeration.
- One sub-module, `cpu0_arb_rr2`: the 2-way round-robin picker. Inputs: req[1:0] and `last`. Outputs: a valid flag and the winner id.
- FSM, counter and datapath registers live in the top level.

## Test plan
- **Reset:** assert reset 3 cycles while `m0_req`=1 -> all outputs 0, no `mem_en`; after release, m0 is granted with `mem_en` in cycle 1.
- **Single read:** ACCESS_CYCLES=1, m0 reads INT32 at 'h0010, memory returns 'hDEADBEEF -> `mem_en` for 1 cycle, `m0_ack` in cycle 2, `m0_rdata`='hDEADBEEF, `m0_err`=0.
- **Contention:** both masters request continuously (m0 read 'h0, m1 write 'h20 value 'h12345678, BYTE) -> grant order 0,1,0,1. Memory sees `mem_rw`=0, `mem_size`=0, `mem_wdata`='h12345678 for m1. Each ack follows its access by 1 cycle.
- **Out of range:** m1 reads at 'h6FFD -> no `mem_en`, `m1_ack` with `m1_err`=1 and `m1_rdata`=0 in cycle 1. An access at 'h6FFC succeeds.
- **Wait states:** ACCESS_CYCLES=4 -> `mem_en` high 4 cycles with `mem_abus` stable, ack in cycle 5, next grant no earlier than cycle 6.
- **Abort:** reset asserted in the 2nd ACCESS cycle with ACCESS_CYCLES=4 -> no ack, `mem_en` 0 the next cycle, state IDLE, `last`=1.
